// File: rtl/register_file_mp_if.sv
// Bus bundle for the multi-port register file: read ports, write ports and
// the single destination-reservation port. The issue/writeback side uses
// the master modport, the register file uses the slave modport.
interface register_file_mp_if #(
  parameter int REG_COUNT = 32,
  parameter int REG_W     = 32,
  parameter int REG_IDX_W = $clog2(REG_COUNT),
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 1
);

  logic [NUM_RD-1:0]           rd_en;
  logic [NUM_RD*REG_IDX_W-1:0] rd_reg;
  logic [NUM_RD*REG_W-1:0]     rd_data;
  logic [NUM_RD-1:0]           rd_busy;

  logic [NUM_WR-1:0]           wr_en;
  logic [NUM_WR*REG_IDX_W-1:0] wr_reg;
  logic [NUM_WR*REG_W-1:0]     wr_data;

  logic                        rsv_en;
  logic [REG_IDX_W-1:0]        rsv_reg;

  modport master (
    output rd_en, rd_reg, wr_en, wr_reg, wr_data, rsv_en, rsv_reg,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_en, rd_reg, wr_en, wr_reg, wr_data, rsv_en, rsv_reg,
    output rd_data, rd_busy
  );

endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file with a per-register busy scoreboard.
// Reads are registered (latency 1) and observe the post-edge state of the
// register, so a write or reservation landing on the same edge is visible
// in the data/busy captured by that edge. Among simultaneous writes to one
// register the highest-index write port wins; a reservation to a register
// beats a write to it on the same edge (newer producer issuing while an
// older one retires). Indices >= REG_COUNT never match a register, so they
// read as zero/not-busy and their writes/reservations fall away.
module register_file_mp #(
  parameter int REG_COUNT = 32,
  parameter int REG_W     = 32,
  parameter int REG_IDX_W = $clog2(REG_COUNT),
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 1,
  parameter bit ZERO_REG  = 1'b1
) (
  input  logic               clk,
  input  logic               aresetn,
  register_file_mp_if.slave  bus
);

  logic [REG_W-1:0]        regs_q [REG_COUNT];
  logic [REG_COUNT-1:0]    busy_q;

  logic [REG_W-1:0]        regs_d [REG_COUNT];
  logic [REG_COUNT-1:0]    busy_d;

  logic [NUM_RD*REG_W-1:0] rd_data_q;
  logic [NUM_RD-1:0]       rd_busy_q;
  logic [NUM_RD*REG_W-1:0] rd_data_d;
  logic [NUM_RD-1:0]       rd_busy_d;

  // Next register/busy state: writes in ascending port order (last one wins),
  // then reservation sets busy, then the zero register is forced clean.
  always_comb begin
    for (int r = 0; r < REG_COUNT; r++) begin
      regs_d[r] = regs_q[r];
      busy_d[r] = busy_q[r];
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && (bus.wr_reg[w*REG_IDX_W +: REG_IDX_W] == REG_IDX_W'(r))) begin
          regs_d[r] = bus.wr_data[w*REG_W +: REG_W];
          busy_d[r] = 1'b0;
        end
      end
      if (bus.rsv_en && (bus.rsv_reg == REG_IDX_W'(r))) begin
        busy_d[r] = 1'b1;
      end
      if (ZERO_REG && (r == 0)) begin
        regs_d[r] = '0;
        busy_d[r] = 1'b0;
      end
    end
  end

  // Read muxes select from the post-edge state, giving same-edge bypass;
  // an index that matches no register leaves the zero default in place.
  always_comb begin
    rd_data_d = '0;
    rd_busy_d = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        if (bus.rd_reg[p*REG_IDX_W +: REG_IDX_W] == REG_IDX_W'(r)) begin
          rd_data_d[p*REG_W +: REG_W] = regs_d[r];
          rd_busy_d[p]                = busy_d[r];
        end
      end
    end
  end

  // State and read-port registers; read ports only load when enabled.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        regs_q[r] <= '0;
      end
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      for (int r = 0; r < REG_COUNT; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q <= busy_d;
      for (int p = 0; p < NUM_RD; p++) begin
        if (bus.rd_en[p]) begin
          rd_data_q[p*REG_W +: REG_W] <= rd_data_d[p*REG_W +: REG_W];
          rd_busy_q[p]                <= rd_busy_d[p];
        end
      end
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.rd_busy = rd_busy_q;

endmodule
